// File: rtl/program_counter_pkg.sv
// -----------------------------------------------------------------------------
// program_counter_pkg
//   Shared CPU constants for the program counter. The CPU top passes these into
//   the program_counter parameters so every PC instance agrees on address
//   width, step size and start address.
//
//   PC_WIDTH : address width in bits
//   PC_INC   : byte step between consecutive 32-bit instructions
//   PC_RESET : address the PC returns to on reset
// -----------------------------------------------------------------------------
package program_counter_pkg;

  localparam int unsigned PC_WIDTH = 16;
  localparam int unsigned PC_INC   = 4;
  localparam int unsigned PC_RESET = 0;

endpackage : program_counter_pkg

// File: rtl/program_counter_pc_adder.sv
// -----------------------------------------------------------------------------
// pc_adder
//   Combinational WIDTH-bit adder producing pc + INC. The carry-out is dropped,
//   so an overflowing sum wraps modulo 2^WIDTH.
//
//   Ports:
//     pc_i  [WIDTH-1:0] : current program-counter value
//     sum_o [WIDTH-1:0] : (pc_i + INC) mod 2^WIDTH
// -----------------------------------------------------------------------------
module pc_adder
  import program_counter_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH,
  parameter int unsigned INC   = PC_INC
) (
  input  logic [WIDTH-1:0] pc_i,
  output logic [WIDTH-1:0] sum_o
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  // Sum is declared WIDTH bits wide, so the carry is discarded by truncation.
  assign sum_o = pc_i + INC_W;

endmodule : pc_adder

// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
//   Program counter register for the fetch stage. Holds the current
//   instruction address and advances it by INC on each rising CLK edge where
//   test is 1. Reset is asynchronous and active-low and reloads RESET_VALUE.
//
//   Ports:
//     CLK              : clock, all updates on its rising edge (except reset)
//     RST              : asynchronous active-low reset
//     test             : increment enable, counter advances only when 1
//     out [WIDTH-1:0]  : current PC value, driven straight from the register
// -----------------------------------------------------------------------------
module program_counter
  import program_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = PC_WIDTH,
  parameter int unsigned INC         = PC_INC,
  parameter int unsigned RESET_VALUE = PC_RESET
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             test,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_inc;

  pc_adder #(
    .WIDTH (WIDTH),
    .INC   (INC)
  ) u_pc_adder (
    .pc_i  (pc_q),
    .sum_o (pc_inc)
  );

  // An X/Z enable takes the else branch, so the PC holds instead of going X.
  always_comb begin
    pc_d = pc_q;
    if (test) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q <= RESET_W;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign out = pc_q;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// -----------------------------------------------------------------------------
// tb_program_counter
//   Three program_counter instances share one clock and reset:
//     A : defaults (WIDTH 16, INC 4, RESET 0x0000)
//     B : WIDTH 8, INC 1, RESET 0x10
//     C : WIDTH 16, INC 4, RESET 0xFFF8 (wrap-around)
//   Reference: each instance's expected value is RESET + n*INC modulo 2^WIDTH,
//   where n counts enabled edges seen while out of reset.
// -----------------------------------------------------------------------------
module tb_program_counter;

  logic        clk;
  logic        rst_n;
  logic        test_a, test_b, test_c;
  logic [15:0] out_a;
  logic [7:0]  out_b;
  logic [15:0] out_c;

  int unsigned n_a, n_b, n_c;
  int          checks_total;
  int          checks_failed;

  program_counter #(.WIDTH(16), .INC(4), .RESET_VALUE(0)) u_dut_a (
    .CLK(clk), .RST(rst_n), .test(test_a), .out(out_a)
  );
  program_counter #(.WIDTH(8), .INC(1), .RESET_VALUE('h10)) u_dut_b (
    .CLK(clk), .RST(rst_n), .test(test_b), .out(out_b)
  );
  program_counter #(.WIDTH(16), .INC(4), .RESET_VALUE('hFFF8)) u_dut_c (
    .CLK(clk), .RST(rst_n), .test(test_c), .out(out_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp) begin
      checks_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expect_pc(int unsigned base, int unsigned inc,
                                            int unsigned n, int unsigned width);
    longint unsigned modulus;
    modulus = longint'(1) << width;
    return 32'((longint'(base) + longint'(inc) * longint'(n)) % modulus);
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_a"}, {16'h0, out_a}, expect_pc(0,       4, n_a, 16));
    check({tag, "_b"}, {24'h0, out_b}, expect_pc('h10,    1, n_b, 8));
    check({tag, "_c"}, {16'h0, out_c}, expect_pc('hFFF8,  4, n_c, 16));
    $display("txn %-8s rst_n=%0b a=0x%04h b=0x%02h c=0x%04h", tag, rst_n, out_a, out_b, out_c);
  endtask

  // One clock: drive enables at negedge, count in the model on posedge, check #1 later.
  task automatic step(input string tag, input logic ta, input logic tb, input logic tc);
    @(negedge clk);
    test_a = ta;
    test_b = tb;
    test_c = tc;
    @(posedge clk);
    if (rst_n === 1'b1) begin
      if (ta === 1'b1) n_a++;
      if (tb === 1'b1) n_b++;
      if (tc === 1'b1) n_c++;
    end
    #1;
    check_all(tag);
  endtask

  // Assert reset between clock edges, verify it acts immediately, hold it for
  // `cycles` edges with enables high, then release away from a clock edge.
  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    n_a = 0; n_b = 0; n_c = 0;
    #1;
    check_all("rst_now");
    test_a = 1'b1; test_b = 1'b1; test_c = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check_all("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_a = 1'b0; test_b = 1'b0; test_c = 1'b0;
    #1;
    check_all("rst_rel");
  endtask

  initial begin
    checks_total  = 0;
    checks_failed = 0;
    n_a = 0; n_b = 0; n_c = 0;
    rst_n  = 1'b0;
    test_a = 1'b0; test_b = 1'b0; test_c = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Undriven enable must not advance the counter.
    for (int i = 0; i < 2; i++) step("en_x", 1'bx, 1'bx, 1'bx);

    // Ten counting edges: A to 0x28, B to 0x1A, C wraps through 0x0000.
    for (int i = 0; i < 10; i++) step("count", 1'b1, 1'b1, 1'b1);
    check("count_end_a", {16'h0, out_a}, 32'h0028);

    // Hold for five edges, then resume.
    for (int i = 0; i < 5; i++) step("hold", 1'b0, 1'b0, 1'b0);
    step("resume", 1'b1, 1'b0, 1'b0);
    check("resume_a", {16'h0, out_a}, 32'h002C);

    // Async reset from 0x0010 with C stepping 0xFFFC, 0x0000, 0x0004 after it.
    pulse_reset(1);
    for (int i = 0; i < 4; i++) step("to_10", 1'b1, 1'b0, 1'b0);
    check("at_10_a", {16'h0, out_a}, 32'h0010);
    pulse_reset(3);
    for (int i = 0; i < 3; i++) step("wrap_c", 1'b0, 1'b0, 1'b1);
    check("wrap_c_end", {16'h0, out_c}, 32'h0004);

    // 8-bit variant: 240 increments from 0x10 wrap back to 0x00.
    pulse_reset(1);
    for (int i = 0; i < 240; i++) step("b_run", 1'b0, 1'b1, 1'b0);
    check("b_wrap", {24'h0, out_b}, 32'h0000);

    // Random enables with occasional mid-run asynchronous resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        pulse_reset(int'($urandom_range(1, 3)));
      end else begin
        step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks_total, checks_failed);
    $finish;
  end

endmodule : tb_program_counter
